// File: rtl/apb_slave_regfile.sv
// ----------------------------------------------------------------------------
// apb_slave_regfile
//
// APB slave register bank. Accepts the psel/penable setup/access handshake,
// inserts WAIT_CYCLES wait states into every access phase, and completes the
// transfer with pready (plus pslverr on an address/permission error).
//
// Register map:
//   reg 0            : ID_VALUE, read-only
//   reg 1            : completed-transfer counter, read-only, wraps
//   reg 2..NUM_REGS-1: read/write, reset to 0
//
// Ports:
//   clk, rst    : clock; synchronous active-high reset
//   psel        : APB select
//   penable     : APB enable (access phase)
//   pwrite      : 1 = write, 0 = read
//   paddr       : register index (byte address = register index)
//   pwdata      : write data
//   prdata      : read data, nonzero only in the completion cycle of a good read
//   pready      : transfer completes this cycle
//   pslverr     : error flag, qualified by pready
//   reg_out     : flat register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_strobe   : one-cycle pulse on bit i the cycle after a committed write
//   abort       : one-cycle pulse after psel drops during ACCESS before pready
// ----------------------------------------------------------------------------
module apb_slave_regfile #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_CYCLES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 8'hA5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_strobe,
  output logic                           abort
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  // Wide enough to hold WAIT_CYCLES, never narrower than one bit.
  localparam int                WCNT_W    = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(WAIT_CYCLES);

  logic [0:0]            state_q, state_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] regs_q [2:NUM_REGS-1];
  logic [NUM_REGS-1:0]   strobe_q;
  logic                  abort_q;

  logic                  done;
  logic                  addr_oob;
  logic                  addr_ro;
  logic                  xfer_err;
  logic                  wr_commit;
  logic [DATA_WIDTH-1:0] reg_view [NUM_REGS];
  logic [DATA_WIDTH-1:0] rdata;

  // --------------------------------------------------------------------------
  // Next-state logic. The transfer is defined entirely by the fields latched
  // in the setup phase; access-phase paddr/pwdata are never looked at.
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;

    if (state_q == ST_IDLE) begin
      // penable high while idle is not a setup phase and is ignored.
      if (psel && !penable) begin
        addr_d  = paddr;
        write_d = pwrite;
        wdata_d = pwdata;
        wcnt_d  = WCNT_LOAD;
        state_d = ST_ACCESS;
      end
    end else begin
      if (!psel) begin
        state_d = ST_IDLE;
        wcnt_d  = '0;
      end else if (penable) begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Completion, error decode and read mux (all combinational from state).
  // --------------------------------------------------------------------------
  assign done      = (state_q == ST_ACCESS) && psel && penable && (wcnt_q == '0);
  // One extra bit so NUM_REGS == 2^ADDR_WIDTH compares correctly.
  assign addr_oob  = {1'b0, addr_q} >= (ADDR_WIDTH + 1)'(NUM_REGS);
  assign addr_ro   = addr_q < ADDR_WIDTH'(2);
  assign xfer_err  = addr_oob || (write_q && addr_ro);
  assign wr_commit = done && write_q && !xfer_err;

  always_comb begin
    reg_view[0] = ID_VALUE;
    reg_view[1] = cnt_q;
    for (int i = 2; i < NUM_REGS; i++) begin
      reg_view[i] = regs_q[i];
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_q == ADDR_WIDTH'(i)) begin
        rdata = reg_view[i];
      end
    end
  end

  assign pready  = done;
  assign pslverr = done && xfer_err;
  assign prdata  = (done && !write_q && !xfer_err) ? rdata : '0;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = reg_view[g];
  end

  assign wr_strobe = strobe_q;
  assign abort     = abort_q;

  // --------------------------------------------------------------------------
  // State registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      strobe_q <= '0;
      abort_q  <= 1'b0;
      // NOTE: the register array is architecturally visible with a defined
      // reset value of 0, so it is reset like any other flop rather than being
      // treated as an unreset memory.
      for (int i = 2; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;

      // Counts every completed transfer, errored or not.
      if (done) begin
        cnt_q <= cnt_q + DATA_WIDTH'(1);
      end

      strobe_q <= '0;
      for (int i = 2; i < NUM_REGS; i++) begin
        if (wr_commit && (addr_q == ADDR_WIDTH'(i))) begin
          regs_q[i]   <= wdata_q;
          strobe_q[i] <= 1'b1;
        end
      end

      // psel dropped in ACCESS means pready has not been given yet.
      abort_q <= (state_q == ST_ACCESS) && !psel;
    end
  end

endmodule
